regfile: RTL and testbench

- General-purpose register file for the NaiveMIPS datapath.
- It is the responder end of the write-back register write channel. The WB stage drives a register index and data on the `sram` interface in master modport. This block accepts the write as slave.
- Serves two combinational read ports to ID, with same-cycle write-to-read bypass.
- Also holds the HI/LO pair, and emits a registered commit trace for the debug/difftest harness.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_rport.sv | 39 +++
 rtl/regfile.sv | 121 ++++++++++++
 tb/tb_regfile.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared datapath widths and register-index constants for the NaiveMIPS core.
// The write-back stage already uses these definitions.
package regfile_pkg;
    localparam int W_REGF = 5;
    localparam int W_DATA = 32;
    localparam int W_ADDR = 32;

    localparam logic [W_REGF-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_rport.sv
// One combinational GPR read port.
// Register 0 and out-of-range indices read as zero; a matching write in the same cycle is forwarded.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = W_DATA
) (
    input  logic [W_REGF-1:0]          idx,
    input  logic [NREG-1:0][DW-1:0]    gpr,
    input  logic                       byp_en,
    input  logic [W_REGF-1:0]          byp_idx,
    input  logic [DW-1:0]              byp_data,
    output logic [DW-1:0]              data
);

    logic in_range_s;

    generate
        if (NREG < (1 << W_REGF)) begin : g_range
            assign in_range_s = (32'(idx) < 32'(NREG));
        end else begin : g_full
            assign in_range_s = 1'b1;
        end
    endgenerate

    // Read mux: zero register first, then write-first bypass, then array contents.
    always_comb begin
        data = '0;
        if ((idx == REG_ZERO) || !in_range_s) begin
            data = '0;
        end else if (byp_en && (byp_idx == idx)) begin
            data = byp_data;
        end else begin
            data = gpr[idx];
        end
    end

endmodule

// File: rtl/regfile.sv
// NaiveMIPS general-purpose register file with HI/LO pair and a registered commit trace.
// Accepts the write-back register write every cycle; reads are combinational with bypass.
module regfile
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = W_DATA
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [W_REGF-1:0]   rd_regf,
    input  logic [DW-1:0]       rd_data,
    input  logic [W_ADDR-1:0]   wb_pc,
    input  logic                wb_valid,
    input  logic [W_REGF-1:0]   rs_regf,
    output logic [DW-1:0]       rs_data,
    input  logic [W_REGF-1:0]   rt_regf,
    output logic [DW-1:0]       rt_data,
    input  logic [1:0]          hilo_we,
    input  logic [DW-1:0]       hi_wdata,
    input  logic [DW-1:0]       lo_wdata,
    output logic [DW-1:0]       hi_data,
    output logic [DW-1:0]       lo_data,
    output logic [W_ADDR-1:0]   dbg_pc,
    output logic [3:0]          dbg_wen,
    output logic [W_REGF-1:0]   dbg_wnum,
    output logic [DW-1:0]       dbg_wdata
);

    logic [NREG-1:0][DW-1:0] gpr_r;
    logic [DW-1:0]           hi_r;
    logic [DW-1:0]           lo_r;
    logic                    wr_in_range_s;
    logic                    wr_en_s;

    generate
        if (NREG < (1 << W_REGF)) begin : g_wr_range
            assign wr_in_range_s = (32'(rd_regf) < 32'(NREG));
        end else begin : g_wr_full
            assign wr_in_range_s = 1'b1;
        end
    endgenerate

    assign wr_en_s = wb_valid && (rd_regf != REG_ZERO) && wr_in_range_s;

    // GPR array update; index 0 is never written so it stays zero from reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpr_r <= '0;
        end else if (wr_en_s) begin
            gpr_r[rd_regf] <= rd_data;
        end
    end

    regfile_rport #(.NREG(NREG), .DW(DW)) u_rport_rs (
        .idx      (rs_regf),
        .gpr      (gpr_r),
        .byp_en   (wr_en_s),
        .byp_idx  (rd_regf),
        .byp_data (rd_data),
        .data     (rs_data)
    );

    regfile_rport #(.NREG(NREG), .DW(DW)) u_rport_rt (
        .idx      (rt_regf),
        .gpr      (gpr_r),
        .byp_en   (wr_en_s),
        .byp_idx  (rd_regf),
        .byp_data (rd_data),
        .data     (rt_data)
    );

    // HI/LO halves, independently enabled; not qualified by wb_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (hilo_we[1]) begin
                hi_r <= hi_wdata;
            end
            if (hilo_we[0]) begin
                lo_r <= lo_wdata;
            end
        end
    end

    // HI/LO write-first bypass to the readers.
    always_comb begin
        hi_data = hi_r;
        lo_data = lo_r;
        if (hilo_we[1]) begin
            hi_data = hi_wdata;
        end else begin
            hi_data = hi_r;
        end
        if (hilo_we[0]) begin
            lo_data = lo_wdata;
        end else begin
            lo_data = lo_r;
        end
    end

    // Commit trace: captures retiring instructions, holds across bubbles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dbg_pc    <= '0;
            dbg_wen   <= 4'h0;
            dbg_wnum  <= '0;
            dbg_wdata <= '0;
        end else begin
            dbg_wen <= (wb_valid && (rd_regf != REG_ZERO)) ? 4'hF : 4'h0;
            if (wb_valid) begin
                dbg_pc    <= wb_pc;
                dbg_wnum  <= rd_regf;
                dbg_wdata <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random traffic,
// all compared against a behavioural register-file model.
module tb_regfile;

    logic        clk;
    logic        resetn;
    logic [4:0]  rd_regf;
    logic [31:0] rd_data;
    logic [31:0] wb_pc;
    logic        wb_valid;
    logic [4:0]  rs_regf;
    logic [31:0] rs_data;
    logic [4:0]  rt_regf;
    logic [31:0] rt_data;
    logic [1:0]  hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic [31:0] dbg_pc;
    logic [3:0]  dbg_wen;
    logic [4:0]  dbg_wnum;
    logic [31:0] dbg_wdata;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] gpr_m [32];
    logic [31:0] hi_m, lo_m;
    logic [31:0] pc_m, wdata_m;
    logic [3:0]  wen_m;
    logic [4:0]  wnum_m;

    regfile dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_regf   (rd_regf),
        .rd_data   (rd_data),
        .wb_pc     (wb_pc),
        .wb_valid  (wb_valid),
        .rs_regf   (rs_regf),
        .rs_data   (rs_data),
        .rt_regf   (rt_regf),
        .rt_data   (rt_data),
        .hilo_we   (hilo_we),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata),
        .hi_data   (hi_data),
        .lo_data   (lo_data),
        .dbg_pc    (dbg_pc),
        .dbg_wen   (dbg_wen),
        .dbg_wnum  (dbg_wnum),
        .dbg_wdata (dbg_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) gpr_m[i] = 32'h0;
        hi_m = 32'h0; lo_m = 32'h0;
        pc_m = 32'h0; wdata_m = 32'h0; wen_m = 4'h0; wnum_m = 5'd0;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_valid && rd_regf == idx) return rd_data;
        return gpr_m[idx];
    endfunction

    task automatic drive(input logic wv, input logic [4:0] rd, input logic [31:0] d,
                         input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] hwe, input logic [31:0] hw, input logic [31:0] lw);
        wb_valid = wv; rd_regf = rd; rd_data = d; wb_pc = pc;
        rs_regf = rs; rt_regf = rt; hilo_we = hwe; hi_wdata = hw; lo_wdata = lw;
    endtask

    // One clock: check combinational outputs, take the edge, check the trace.
    task automatic cycle();
        #2;
        check("rs_data", rs_data, ref_read(rs_regf));
        check("rt_data", rt_data, ref_read(rt_regf));
        check("hi_data", hi_data, hilo_we[1] ? hi_wdata : hi_m);
        check("lo_data", lo_data, hilo_we[0] ? lo_wdata : lo_m);
        @(posedge clk);
        if (resetn) begin
            if (wb_valid && rd_regf != 5'd0) gpr_m[rd_regf] = rd_data;
            if (hilo_we[1]) hi_m = hi_wdata;
            if (hilo_we[0]) lo_m = lo_wdata;
            wen_m = (wb_valid && rd_regf != 5'd0) ? 4'hF : 4'h0;
            if (wb_valid) begin
                pc_m = wb_pc; wnum_m = rd_regf; wdata_m = rd_data;
            end
        end
        #1;
        check("dbg_pc", dbg_pc, pc_m);
        check("dbg_wen", {28'h0, dbg_wen}, {28'h0, wen_m});
        check("dbg_wnum", {27'h0, dbg_wnum}, {27'h0, wnum_m});
        check("dbg_wdata", dbg_wdata, wdata_m);
    endtask

    initial begin
        resetn = 1'b0;
        model_reset();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_dbg_wen", {28'h0, dbg_wen}, 32'h0);
        check("rst_hi", hi_data, 32'h0);
        check("rst_lo", lo_data, 32'h0);

        // Mid-run reset discards state and an in-flight write
        drive(1'b1, 5'd5, 32'h1234, 32'h100, 5'd0, 5'd0, 2'b11, 32'h77, 32'h88);
        cycle();
        drive(1'b1, 5'd9, 32'h9999, 32'h104, 5'd5, 5'd9, 2'b11, 32'h55, 32'h66);
        #1;
        resetn = 1'b0;
        model_reset();
        cycle();
        check("rst_rs5", rs_data, 32'h0);
        check("rst_wen", {28'h0, dbg_wen}, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd9, 2'b00, 32'h0, 32'h0);
        #1;
        resetn = 1'b1;
        cycle();
        check("rst_rt9", rt_data, 32'h0);
        check("rst_hi0", hi_data, 32'h0);

        // Zero register never written; trace still records the retirement
        drive(1'b1, 5'd0, 32'hDEADBEEF, 32'h200, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        cycle();
        check("zero_pc", dbg_pc, 32'h200);
        drive(1'b0, 5'd0, 32'h0, 32'h204, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        cycle();

        // Back-to-back writes then read
        drive(1'b1, 5'd31, 32'hCAFE0001, 32'h300, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        cycle();
        drive(1'b1, 5'd1, 32'h00000002, 32'h304, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h308, 5'd31, 5'd1, 2'b00, 32'h0, 32'h0);
        #1;
        check("rd31", rs_data, 32'hCAFE0001);
        check("rd1", rt_data, 32'h00000002);
        check("wnum1", {27'h0, dbg_wnum}, 32'h1);
        check("wdata1", dbg_wdata, 32'h2);
        cycle();

        // Bypass with and without wb_valid
        drive(1'b1, 5'd7, 32'h11, 32'h400, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        cycle();
        drive(1'b0, 5'd7, 32'h22, 32'h404, 5'd7, 5'd7, 2'b00, 32'h0, 32'h0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h408, 5'd7, 5'd7, 2'b00, 32'h0, 32'h0);
        #1;
        check("nobyp_rs", rs_data, 32'h11);
        cycle();
        drive(1'b1, 5'd7, 32'h22, 32'h40C, 5'd7, 5'd7, 2'b00, 32'h0, 32'h0);
        #1;
        check("byp_rs", rs_data, 32'h22);
        check("byp_rt", rt_data, 32'h22);
        cycle();

        // HI/LO half writes
        drive(1'b0, 5'd0, 32'h0, 32'h500, 5'd0, 5'd0, 2'b10, 32'hA5, 32'hFF);
        #1;
        check("hi_byp", hi_data, 32'hA5);
        check("lo_keep", lo_data, 32'h0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h504, 5'd0, 5'd0, 2'b11, 32'h1, 32'h2);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h508, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        #1;
        check("hi_reg", hi_data, 32'h1);
        check("lo_reg", lo_data, 32'h2);
        cycle();

        // Trace hold across bubbles
        drive(1'b1, 5'd3, 32'h33, 32'hBFC00010, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'($urandom_range(0, 31)), $urandom, $urandom, 5'd3, 5'd0,
                  2'b00, 32'h0, 32'h0);
            cycle();
        end
        check("hold_pc", dbg_pc, 32'hBFC00010);
        check("hold_wnum", {27'h0, dbg_wnum}, 32'h3);
        check("hold_wdata", dbg_wdata, 32'h33);
        check("hold_wen", {28'h0, dbg_wen}, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            logic [4:0] rs;
            logic [4:0] rt;
            rd = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), rd, $urandom, $urandom, rs, rt,
                  2'($urandom_range(0, 3)), $urandom, $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
